// File: rtl/uram_pkg.sv
// Shared types and helpers for the UltraRAM simple-dual-port wrapper.
package uram_pkg;

  localparam int AWIDTH_DEF = 12;
  localparam int DWIDTH_DEF = 72;
  localparam int NBYTES     = DWIDTH_DEF / 8;
  localparam int DEPTH      = 1 << AWIDTH_DEF;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic logic [7:0] be_merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/uram_core.sv
// UltraRAM array: byte-enable write port, registered read port with
// selectable same-address read-during-write result.
module uram_core
  import uram_pkg::*;
#(
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AWIDTH-1:0]   waddr,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] wbe,
  input  logic                re,
  input  logic [AWIDTH-1:0]   raddr,
  output logic [DWIDTH-1:0]   rdata
);

  localparam int NB  = DWIDTH / 8;
  localparam int DEP = 1 << AWIDTH;

  (* ram_style = "ultra" *)
  logic [DWIDTH-1:0] mem [DEP];

  logic [DWIDTH-1:0] old_w;
  logic [DWIDTH-1:0] fwd;
  logic              bypass;

  assign old_w  = mem[raddr];
  assign bypass = (RDW_MODE != 0) && we && (waddr == raddr);

  // Bypass only replaces the bytes this cycle's write enables.
  always_comb begin
    fwd = old_w;
    for (int i = 0; i < NB; i++) begin
      fwd[8*i +: 8] = be_merge(old_w[8*i +: 8], wdata[8*i +: 8],
                               bypass & wbe[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= fwd;
  end

endmodule

// File: rtl/uram_sdp_pipe.sv
// SDP UltraRAM wrapper: zero sweep FSM, accept logic and a stallable
// read-data pipeline with valid tracking.
module uram_sdp_pipe
  import uram_pkg::*;
#(
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int NBPIPE    = 3,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AWIDTH-1:0]   wr_addr,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic [DWIDTH/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [AWIDTH-1:0]   rd_addr,
  input  logic                regce,
  output logic                rd_ready,
  output logic                rd_valid,
  output logic [DWIDTH-1:0]   rd_data,
  output logic                init_done
);

  localparam int NB = DWIDTH / 8;

  state_t              state;
  logic [AWIDTH-1:0]   cnt;
  logic                init_q;
  logic                sweep;
  logic                rd_acc;
  logic                wr_acc;
  logic                c_we;
  logic [AWIDTH-1:0]   c_waddr;
  logic [DWIDTH-1:0]   c_wdata;
  logic [NB-1:0]       c_wbe;
  logic [DWIDTH-1:0]   arr_q;
  logic                v_arr;
  logic [NBPIPE-1:0]   v_pipe;
  logic [DWIDTH-1:0]   d_pipe [NBPIPE];

  assign sweep    = (state == INIT);
  assign rd_ready = init_q & regce;
  assign rd_acc   = rd_ready & rd_en;
  assign wr_acc   = init_q & wr_en;

  assign c_we    = wr_acc | sweep;
  assign c_waddr = sweep ? cnt : wr_addr;
  assign c_wdata = sweep ? '0 : wr_data;
  assign c_wbe   = sweep ? '1 : wr_be;

  uram_core #(
    .AWIDTH   (AWIDTH),
    .DWIDTH   (DWIDTH),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk   (clk),
    .we    (c_we),
    .waddr (c_waddr),
    .wdata (c_wdata),
    .wbe   (c_wbe),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (arr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= (INIT_ZERO != 0) ? INIT : RUN;
      cnt    <= '0;
      init_q <= (INIT_ZERO == 0);
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state  <= RUN;
            init_q <= 1'b1;
          end
        end
        RUN: ;
        default: ;
      endcase
    end
  end

  // Data stages load only behind a valid so rd_data holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_arr  <= 1'b0;
      v_pipe <= '0;
      for (int i = 0; i < NBPIPE; i++) d_pipe[i] <= '0;
    end else if (regce) begin
      v_arr     <= rd_acc;
      v_pipe[0] <= v_arr;
      if (v_arr) d_pipe[0] <= arr_q;
      for (int i = 1; i < NBPIPE; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  assign rd_valid  = v_pipe[NBPIPE-1];
  assign rd_data   = d_pipe[NBPIPE-1];
  assign init_done = init_q;

endmodule
